// File: rtl/cxapb_arbiter_pkg.sv
// Shared types and default widths for the two-port APB3 arbiter.
package cxapb_arbiter_pkg;

  localparam int unsigned DefAddrWidth = 32;
  localparam int unsigned DefDataWidth = 32;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StAccess = 2'd2,
    StResp   = 2'd3
  } state_e;

  typedef logic port_idx_t;

endpackage

// File: rtl/cxapb_rr_arb2.sv
// Two-requester round-robin grant selection; purely combinational, pointer held by the parent.
module cxapb_rr_arb2
  import cxapb_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  port_idx_t  last,
  output port_idx_t  grant,
  output logic       any_req
);

  always_comb begin
    any_req = |req;
    grant   = 1'b0;
    if (req == 2'b11) begin
      grant = ~last;
    end else if (req[1]) begin
      grant = 1'b1;
    end
  end

endmodule

// File: rtl/cxapb_arbiter.sv
// Shares one APB3 master port between two requester ports with round-robin arbitration.
module cxapb_arbiter
  import cxapb_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned DATA_WIDTH = DefDataWidth
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  pclken,
  input  logic                  psel0,
  input  logic                  penable0,
  input  logic                  pwrite0,
  input  logic [ADDR_WIDTH-1:0] paddr0,
  input  logic [DATA_WIDTH-1:0] pwdata0,
  output logic [DATA_WIDTH-1:0] prdata0,
  output logic                  pready0,
  output logic                  pslverr0,
  input  logic                  psel1,
  input  logic                  penable1,
  input  logic                  pwrite1,
  input  logic [ADDR_WIDTH-1:0] paddr1,
  input  logic [DATA_WIDTH-1:0] pwdata1,
  output logic [DATA_WIDTH-1:0] prdata1,
  output logic                  pready1,
  output logic                  pslverr1,
  output logic                  pselm,
  output logic                  penablem,
  output logic                  pwritem,
  output logic [ADDR_WIDTH-1:0] paddrm,
  output logic [DATA_WIDTH-1:0] pwdatam,
  input  logic [DATA_WIDTH-1:0] prdatam,
  input  logic                  preadym,
  input  logic                  pslverrm
);

  state_e                  state_q, state_d;
  port_idx_t               last_q, last_d;
  port_idx_t               gnt_q, gnt_d;
  logic                    pselm_q, pselm_d;
  logic                    penablem_q, penablem_d;
  logic                    pwritem_q, pwritem_d;
  logic [ADDR_WIDTH-1:0]   paddrm_q, paddrm_d;
  logic [DATA_WIDTH-1:0]   pwdatam_q, pwdatam_d;
  logic [DATA_WIDTH-1:0]   prdata0_q, prdata0_d;
  logic [DATA_WIDTH-1:0]   prdata1_q, prdata1_d;
  logic [1:0]              pready_q, pready_d;
  logic [1:0]              pslverr_q, pslverr_d;

  port_idx_t arb_grant;
  logic      arb_any;
  logic      gnt_psel;

  // A requester is sampled on psel alone, so its enable is not needed.
  logic unused_penable;
  assign unused_penable = penable0 ^ penable1;

  cxapb_rr_arb2 u_rr_arb2 (
    .req     ({psel1, psel0}),
    .last    (last_q),
    .grant   (arb_grant),
    .any_req (arb_any)
  );

  assign gnt_psel = gnt_q ? psel1 : psel0;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    gnt_d      = gnt_q;
    pselm_d    = pselm_q;
    penablem_d = penablem_q;
    pwritem_d  = pwritem_q;
    paddrm_d   = paddrm_q;
    pwdatam_d  = pwdatam_q;
    prdata0_d  = prdata0_q;
    prdata1_d  = prdata1_q;
    pready_d   = pready_q;
    pslverr_d  = pslverr_q;

    unique case (state_q)
      StIdle: begin
        if (arb_any) begin
          gnt_d      = arb_grant;
          last_d     = arb_grant;
          pselm_d    = 1'b1;
          penablem_d = 1'b0;
          pwritem_d  = arb_grant ? pwrite1 : pwrite0;
          paddrm_d   = arb_grant ? paddr1 : paddr0;
          pwdatam_d  = arb_grant ? pwdata1 : pwdata0;
          state_d    = StSetup;
        end
      end
      StSetup: begin
        penablem_d = 1'b1;
        state_d    = StAccess;
      end
      StAccess: begin
        if (preadym) begin
          pselm_d    = 1'b0;
          penablem_d = 1'b0;
          state_d    = StResp;
          // A requester that abandoned its transfer gets no response.
          if (gnt_psel) begin
            pready_d[gnt_q]  = 1'b1;
            pslverr_d[gnt_q] = pslverrm;
            if (gnt_q) begin
              prdata1_d = prdatam;
            end else begin
              prdata0_d = prdatam;
            end
          end
        end
      end
      StResp: begin
        pready_d  = 2'b00;
        pslverr_d = 2'b00;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q    <= StIdle;
      last_q     <= 1'b1;
      gnt_q      <= 1'b0;
      pselm_q    <= 1'b0;
      penablem_q <= 1'b0;
      pwritem_q  <= 1'b0;
      paddrm_q   <= '0;
      pwdatam_q  <= '0;
      prdata0_q  <= '0;
      prdata1_q  <= '0;
      pready_q   <= 2'b00;
      pslverr_q  <= 2'b00;
    end else if (pclken) begin
      state_q    <= state_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      pselm_q    <= pselm_d;
      penablem_q <= penablem_d;
      pwritem_q  <= pwritem_d;
      paddrm_q   <= paddrm_d;
      pwdatam_q  <= pwdatam_d;
      prdata0_q  <= prdata0_d;
      prdata1_q  <= prdata1_d;
      pready_q   <= pready_d;
      pslverr_q  <= pslverr_d;
    end
  end

  assign pselm    = pselm_q;
  assign penablem = penablem_q;
  assign pwritem  = pwritem_q;
  assign paddrm   = paddrm_q;
  assign pwdatam  = pwdatam_q;
  assign prdata0  = prdata0_q;
  assign prdata1  = prdata1_q;
  assign pready0  = pready_q[0];
  assign pready1  = pready_q[1];
  assign pslverr0 = pslverr_q[0];
  assign pslverr1 = pslverr_q[1];

endmodule

// File: tb/tb_cxapb_arbiter.sv
// Self-checking bench for cxapb_arbiter: directed scenarios plus a randomized transaction-level run.
module tb_cxapb_arbiter;

  logic        pclk = 1'b0;
  logic        preset, pclken;
  logic [1:0]  psel, penable, pwrite;
  logic [31:0] paddr [2];
  logic [31:0] pwdata [2];
  logic [31:0] prdata0, prdata1, paddrm, pwdatam;
  logic        pready0, pready1, pslverr0, pslverr1;
  logic        pselm, penablem, pwritem;
  logic [31:0] prdatam;
  logic        preadym, pslverrm;

  logic [1:0]  rdy, err;
  logic [31:0] rdata [2];
  assign rdy      = {pready1, pready0};
  assign err      = {pslverr1, pslverr0};
  assign rdata[0] = prdata0;
  assign rdata[1] = prdata1;

  int total = 0;
  int bad   = 0;

  always #5 pclk = ~pclk;

  cxapb_arbiter dut (
    .pclk     (pclk),
    .preset   (preset),
    .pclken   (pclken),
    .psel0    (psel[0]),
    .penable0 (penable[0]),
    .pwrite0  (pwrite[0]),
    .paddr0   (paddr[0]),
    .pwdata0  (pwdata[0]),
    .prdata0  (prdata0),
    .pready0  (pready0),
    .pslverr0 (pslverr0),
    .psel1    (psel[1]),
    .penable1 (penable[1]),
    .pwrite1  (pwrite[1]),
    .paddr1   (paddr[1]),
    .pwdata1  (pwdata[1]),
    .prdata1  (prdata1),
    .pready1  (pready1),
    .pslverr1 (pslverr1),
    .pselm    (pselm),
    .penablem (penablem),
    .pwritem  (pwritem),
    .paddrm   (paddrm),
    .pwdatam  (pwdatam),
    .prdatam  (prdatam),
    .preadym  (preadym),
    .pslverrm (pslverrm)
  );

  task automatic tick;
    @(posedge pclk);
    #1;
  endtask

  task automatic clear_inputs;
    psel = 2'b00; penable = 2'b00; pwrite = 2'b00;
    paddr[0] = '0; paddr[1] = '0; pwdata[0] = '0; pwdata[1] = '0;
    preadym = 1'b0; prdatam = '0; pslverrm = 1'b0;
  endtask

  task automatic do_reset;
    clear_inputs();
    pclken = 1'b1;
    preset = 1'b1;
    tick();
    tick();
    preset = 1'b0;
  endtask

  task automatic wait_rdy(input int p, input string name);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      tick();
      if (rdy[p]) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s: pready%0d never rose within 30 cycles (got rdy=%b)", name, p, rdy);
    end
  endtask

  task automatic test_reset;
    clear_inputs();
    pclken = 1'b0;
    preset = 1'b1;
    tick();
    total++;
    if ({pselm, penablem, pwritem, pready0, pready1, pslverr0, pslverr1} !== 7'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 0000000",
               {pselm, penablem, pwritem, pready0, pready1, pslverr0, pslverr1});
    end
    total++;
    if ({paddrm, pwdatam, prdata0, prdata1} !== 128'b0) begin
      bad++;
      $display("FAIL reset_data: got %h %h %h %h want all zero", paddrm, pwdatam, prdata0, prdata1);
    end
    pclken = 1'b1;
    preset = 1'b0;
  endtask

  task automatic test_single_read;
    do_reset();
    paddr[0] = 32'h4000_0010; pwrite[0] = 1'b0; psel[0] = 1'b1;
    preadym = 1'b1; prdatam = 32'hDEAD_BEEF;
    tick();
    total++;
    if ({pselm, penablem} !== 2'b10 || paddrm !== 32'h4000_0010) begin
      bad++;
      $display("FAIL read_setup: got sel/en=%b addr=%h want 10 40000010", {pselm, penablem}, paddrm);
    end
    penable[0] = 1'b1;
    tick();
    total++;
    if ({pselm, penablem, pready0} !== 3'b110) begin
      bad++;
      $display("FAIL read_access: got sel/en/rdy=%b want 110", {pselm, penablem, pready0});
    end
    tick();
    total++;
    if (pready0 !== 1'b1 || prdata0 !== 32'hDEAD_BEEF || pslverr0 !== 1'b0) begin
      bad++;
      $display("FAIL read_resp: got rdy=%b data=%h err=%b want 1 deadbeef 0", pready0, prdata0, pslverr0);
    end
    total++;
    if (pready1 !== 1'b0 || pselm !== 1'b0) begin
      bad++;
      $display("FAIL read_other: got pready1=%b pselm=%b want 0 0", pready1, pselm);
    end
    psel[0] = 1'b0; penable[0] = 1'b0;
    tick();
    total++;
    if (pready0 !== 1'b0) begin
      bad++;
      $display("FAIL read_one_cycle: got pready0=%b want 0", pready0);
    end
  endtask

  task automatic test_contention;
    int   exp_port;
    logic seen;
    logic [1:0] exp_rdy;
    do_reset();
    pwrite = 2'b11; paddr[0] = 32'h0000_0100; paddr[1] = 32'h0000_0200;
    pwdata[0] = $urandom; pwdata[1] = $urandom;
    psel = 2'b11; preadym = 1'b1;
    exp_port = 0;
    for (int n = 0; n < 4; n++) begin
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
        tick();
        if (pselm && !penablem) seen = 1'b1;
      end
      total++;
      if (!seen || paddrm !== paddr[exp_port] || pwdatam !== pwdata[exp_port]) begin
        bad++;
        $display("FAIL rr_order[%0d]: got seen=%b addr=%h data=%h want port %0d addr=%h data=%h",
                 n, seen, paddrm, pwdatam, exp_port, paddr[exp_port], pwdata[exp_port]);
      end
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
        tick();
        if (rdy != 2'b00) seen = 1'b1;
      end
      exp_rdy = (exp_port == 1) ? 2'b10 : 2'b01;
      total++;
      if (rdy !== exp_rdy) begin
        bad++;
        $display("FAIL rr_ready[%0d]: got rdy=%b want %b", n, rdy, exp_rdy);
      end
      paddr[exp_port]  = paddr[exp_port] + 32'd4;
      pwdata[exp_port] = $urandom;
      exp_port = 1 - exp_port;
    end
    psel = 2'b00;
    tick();
    tick();
  endtask

  task automatic test_wait_err;
    do_reset();
    psel[1] = 1'b1; pwrite[1] = 1'b1; paddr[1] = 32'h0000_0A40; pwdata[1] = 32'h1234_5678;
    preadym = 1'b0; pslverrm = 1'b1;
    tick();
    penable[1] = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if ({penablem, pwritem, pready1, paddrm, pwdatam} !== {3'b110, 32'h0000_0A40, 32'h1234_5678})
      begin
        bad++;
        $display("FAIL wait_hold[%0d]: got en/wr/rdy=%b addr=%h data=%h want 110 00000a40 12345678",
                 i, {penablem, pwritem, pready1}, paddrm, pwdatam);
      end
    end
    preadym = 1'b1; prdatam = $urandom;
    tick();
    total++;
    if ({pready1, pslverr1, pready0, pselm} !== 4'b1100) begin
      bad++;
      $display("FAIL wait_resp: got rdy1/err1/rdy0/sel=%b want 1100", {pready1, pslverr1, pready0, pselm});
    end
    psel[1] = 1'b0; penable[1] = 1'b0; preadym = 1'b0; pslverrm = 1'b0;
    tick();
    total++;
    if ({pready1, pslverr1} !== 2'b00) begin
      bad++;
      $display("FAIL wait_err_clear: got rdy1/err1=%b want 00", {pready1, pslverr1});
    end
  endtask

  task automatic test_clken;
    int e;
    logic [31:0] val;
    do_reset();
    val = $urandom;
    psel[0] = 1'b1; paddr[0] = 32'h0000_0C00; preadym = 1'b1; prdatam = val;
    e = 0;
    for (int c = 0; c < 60 && e < 5; c++) begin
      pclken = 1'($urandom_range(0, 1));
      tick();
      if (pclken) e++;
      total++;
      if ({pselm, penablem, pready0} !== {(e == 1 || e == 2), (e == 2), (e == 3)}) begin
        bad++;
        $display("FAIL clken[%0d]: got sel/en/rdy=%b after %0d enabled edges",
                 c, {pselm, penablem, pready0}, e);
      end
      if (pready0) begin
        total++;
        if (prdata0 !== val) begin
          bad++;
          $display("FAIL clken_data: got %h want %h", prdata0, val);
        end
        psel[0] = 1'b0;
      end
    end
    total++;
    if (e < 5) begin
      bad++;
      $display("FAIL clken_progress: got %0d enabled edges want 5", e);
    end
    pclken = 1'b1;
    psel[0] = 1'b0;
  endtask

  task automatic test_reset_mid;
    do_reset();
    psel[0] = 1'b1; paddr[0] = 32'h0000_0300; preadym = 1'b0;
    tick();
    penable[0] = 1'b1;
    tick();
    total++;
    if (penablem !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_access: got penablem=%b want 1", penablem);
    end
    preset = 1'b1;
    tick();
    total++;
    if ({pselm, penablem, pready0, pready1, pslverr0, pslverr1, prdata0, prdata1, paddrm} !== '0) begin
      bad++;
      $display("FAIL rstmid_clear: got sel=%b en=%b rdy=%b err=%b d0=%h d1=%h a=%h want all zero",
               pselm, penablem, rdy, err, prdata0, prdata1, paddrm);
    end
    preset = 1'b0;
    psel = 2'b10; penable = 2'b00; paddr[1] = 32'h0000_0500; preadym = 1'b1;
    tick();
    total++;
    if (pselm !== 1'b1 || paddrm !== 32'h0000_0500) begin
      bad++;
      $display("FAIL rstmid_port1: got pselm=%b addr=%h want 1 00000500", pselm, paddrm);
    end
    wait_rdy(1, "rstmid_done");
    psel = 2'b00;
    tick();
  endtask

  task automatic test_drop_psel;
    do_reset();
    psel[0] = 1'b1; paddr[0] = 32'h0000_0600; preadym = 1'b0;
    tick();
    tick();
    psel[0] = 1'b0; preadym = 1'b1; prdatam = 32'hCAFE_F00D;
    tick();
    total++;
    if ({pready0, pselm, penablem} !== 3'b000 || prdata0 !== 32'h0) begin
      bad++;
      $display("FAIL drop_resp: got rdy0/sel/en=%b data=%h want 000 00000000",
               {pready0, pselm, penablem}, prdata0);
    end
    tick();
    total++;
    if (pready0 !== 1'b0) begin
      bad++;
      $display("FAIL drop_idle: got pready0=%b want 0", pready0);
    end
    preadym = 1'b0;
    psel[1] = 1'b1; paddr[1] = 32'h0000_0700;
    tick();
    total++;
    if (pselm !== 1'b1 || paddrm !== 32'h0000_0700) begin
      bad++;
      $display("FAIL drop_recover: got pselm=%b addr=%h want 1 00000700", pselm, paddrm);
    end
    preadym = 1'b1;
    wait_rdy(1, "drop_recover_done");
    psel = 2'b00;
    tick();
  endtask

  // Transaction-level model: requesters issue random transfers, the slave answers with random
  // waits/data; grants must follow round-robin over the requests present at each arbitration.
  task automatic test_random;
    logic [1:0]  act, prev_req;
    logic [31:0] a [2];
    logic [31:0] w [2];
    logic [31:0] exp_rd [2];
    logic        wr [2];
    logic        exp_er [2];
    logic        exp_v [2];
    logic        lastm;
    int          own;
    int          done [2];
    do_reset();
    act = 2'b00; prev_req = 2'b00; lastm = 1'b1; own = 0;
    for (int p = 0; p < 2; p++) begin
      a[p] = '0; w[p] = '0; wr[p] = 1'b0; exp_v[p] = 1'b0; exp_rd[p] = '0; exp_er[p] = 1'b0;
      done[p] = 0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      if (pselm && !penablem) begin
        if (prev_req == 2'b11) own = lastm ? 0 : 1;
        else own = prev_req[1] ? 1 : 0;
        lastm = (own == 1);
        total++;
        if (prev_req == 2'b00 || {pwritem, paddrm, pwdatam} !== {wr[own], a[own], w[own]}) begin
          bad++;
          $display("FAIL rand_grant[%0d]: req=%b got wr=%b a=%h d=%h want port %0d wr=%b a=%h d=%h",
                   cyc, prev_req, pwritem, paddrm, pwdatam, own, wr[own], a[own], w[own]);
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (rdy[p]) begin
          total++;
          if (!act[p] || !exp_v[p] || rdata[p] !== exp_rd[p] || err[p] !== exp_er[p]) begin
            bad++;
            $display("FAIL rand_resp%0d[%0d]: got data=%h err=%b want data=%h err=%b (pending=%b)",
                     p, cyc, rdata[p], err[p], exp_rd[p], exp_er[p], exp_v[p]);
          end
          act[p] = 1'b0; exp_v[p] = 1'b0; done[p]++;
        end else if (err[p] !== 1'b0) begin
          total++;
          bad++;
          $display("FAIL rand_err%0d[%0d]: got pslverr=%b want 0 outside response", p, cyc, err[p]);
        end
      end
      prdatam  = $urandom;
      pslverrm = 1'($urandom_range(0, 1));
      if (pselm && penablem) begin
        preadym = ($urandom_range(0, 2) != 0);
        if (preadym) begin
          exp_rd[own] = prdatam; exp_er[own] = pslverrm; exp_v[own] = 1'b1;
        end
      end else begin
        preadym = 1'($urandom_range(0, 1));
      end
      for (int p = 0; p < 2; p++) begin
        if (!act[p] && $urandom_range(0, 3) != 0) begin
          act[p] = 1'b1; a[p] = $urandom; w[p] = $urandom; wr[p] = 1'($urandom_range(0, 1));
        end
        penable[p] = act[p] & psel[p];
        psel[p]    = act[p];
        paddr[p]   = a[p];
        pwdata[p]  = w[p];
        pwrite[p]  = wr[p];
      end
      prev_req = psel;
    end
    total++;
    if (done[0] < 100 || done[1] < 100) begin
      bad++;
      $display("FAIL rand_progress: got done0=%0d done1=%0d want >=100 each", done[0], done[1]);
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_wait_err();
    test_clken();
    test_reset_mid();
    test_drop_psel();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cxapb_arbiter.md
# cxapb_arbiter

Two-port APB3 arbiter that shares one APB3 master port between two requesters. The typical master-port load is the slave interface of the APB asynchronous bridge. Each requester sees an ordinary APB3 completer that stalls with its ready held low until its transfer has completed on the shared port. Arbitration is round-robin, and the shared-port outputs and per-port responses are registered. The block sits in the requester clock domain, upstream of the bridge.

## Interface
- ADDR_WIDTH, 32, address width of all ports
- DATA_WIDTH, 32, data width of all ports
- pclk  in  1  clock; all logic is on the rising edge
- preset  in  1  synchronous, active-high reset
- pclken  in  1  clock enable; when low, no state or output register updates
- psel0 / psel1  in  1  select, requester port 0/1
- penable0 / penable1  in  1  enable, port 0/1
- pwrite0 / pwrite1  in  1  write flag, port 0/1
- paddr0 / paddr1  in  ADDR_WIDTH  address, port 0/1
- pwdata0 / pwdata1  in  DATA_WIDTH  write data, port 0/1
- prdata0 / prdata1  out  DATA_WIDTH  read data, port 0/1
- pready0 / pready1  out  1  ready, port 0/1
- pslverr0 / pslverr1  out  1  error, port 0/1
- pselm  out  1  select, shared port
- penablem  out  1  enable, shared port
- pwritem  out  1  write flag, shared port
- paddrm  out  ADDR_WIDTH  address, shared port
- pwdatam  out  DATA_WIDTH  write data, shared port
- prdatam  in  DATA_WIDTH  read data, shared port
- preadym  in  1  ready, shared port
- pslverrm  in  1  error, shared port

## Operation
- State machine, advancing only on pclk edges with pclken=1:
  - IDLE: if any requester port has psel=1, choose a grant, latch that port's paddr/pwrite/pwdata into the master registers, and go to SETUP.
  - SETUP: pselm=1, penablem=0. Go to ACCESS.
  - ACCESS: pselm=1, penablem=1. Hold until preadym=1. On that edge, capture prdatam/pslverrm into the granted port's response registers, drop pselm/penablem, and go to RESP.
  - RESP: pready and pslverr of the granted port are 1 for exactly one enabled cycle; prdata is valid in that cycle. Go to IDLE.
- Round-robin pointer `last`, reset value 1, so port 0 wins the first contention. When both ports request, grant !last. When one port requests, grant it. Update last=grant at the IDLE→SETUP transition.
- A requester is sampled on psel alone, in its setup or access phase. Requesters hold their signals stable until pready, which satisfies APB3.
- The non-granted port sees pready=0 throughout and is serviced on a later pass through IDLE.
- Only the granted port's prdata/pslverr registers update; the other port's registers keep their values.
- prdata is updated on writes as well (prdatam value, don't-care to the requester).
- pslverr is forced to 0 outside the RESP cycle.
- A granted requester that drops psel mid-transfer is a protocol violation. The shared transfer still completes and its response is discarded; there is no hang.
- preset=1 on any edge, regardless of pclken: state=IDLE, last=1, all outputs 0. A shared transfer in progress is abandoned (pselm drops on the next edge). The downstream bridge is reset in the same reset domain.

## Timing
- Reset values: pselm, penablem, pwritem, paddrm, pwdatam, prdata0/1, pready0/1, pslverr0/1 are all 0.
- Minimum latency, with preadym already high and pclken=1 throughout:
  - psel sampled at edge 0 (IDLE→SETUP).
  - ACCESS at edge 1.
  - RESP at edge 2.
  - pready high during cycle 2–3.
  - This gives 3 cycles from psel to pready; each extra preadym-low cycle adds one.
- Back-to-back same port: the earliest new SETUP is 2 cycles after the RESP cycle (RESP→IDLE, then IDLE→SETUP).
- Competing port: granted on the first IDLE after the RESP, so it waits at most one transfer.
- pclken=0 freezes every register, including pready. A RESP lasts one enabled cycle, not one pclk cycle.
- No combinational path from requester inputs or master inputs to any output.

## Structure
- Package cxapb_arbiter_pkg holds:
  - state enum: IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2, RESP=2'd3.
  - port index type (1 bit).
  - default width constants.
- Sub-module cxapb_rr_arb2:
  - inputs: req[1:0], last.
  - outputs: grant index and any_req.
  - purely combinational; the pointer register stays in the parent.
- Everything else (FSM, master registers, response registers) lives in cxapb_arbiter.

## Test plan
- Single read on port 0, paddr0=0x4000_0010, preadym=1, prdatam=0xDEAD_BEEF → pselm at cycle 1, penablem at cycle 2, pready0=1 with prdata0=0xDEAD_BEEF at cycle 3, pready1 stays 0.
- psel0 and psel1 asserted the same cycle after reset, both writes → port 0 transfer first, then port 1. A repeated pair next alternates 1 then 0 only if last=0; check the pointer sequence 0,1,0,1 under continuous contention.
- Port 1 write of 0x1234_5678 with preadym low for 5 cycles and pslverrm=1 → penablem held 5 extra cycles; pready1=1 and pslverr1=1 for one cycle; paddrm/pwdatam stable throughout.
- pclken toggling 1/0 during a port 0 read → the state advances only on enabled edges, and pready0 stays high for exactly one enabled cycle.
- preset pulsed during ACCESS → the next edge shows pselm=0, penablem=0, and all requester-port outputs 0. After release, a fresh port 1 request is granted first (last=1 → port 0 preferred only on contention).
- Port 0 drops psel0 during ACCESS → the shared transfer completes, pready0 stays 0, and the FSM returns to IDLE.
